// File: rtl/fir_pkg.sv
// Shared definitions for the FIR blocks.
//   fir_state_t   : MAC engine sequencer states
//   fir_acc_width : accumulator width that can hold K full-precision
//                   products without overflow
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_HOLD  = 2'd3
    } fir_state_t;

    // One product needs dw+cw bits; summing k of them needs clog2(k) more.
    function automatic int fir_acc_width(input int dw, input int cw, input int k);
        return dw + cw + $clog2(k);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output stage: round-half-up by FRAC_BITS, then saturate
// to a signed OUT_WIDTH result.
//   acc_in : signed ACC_WIDTH accumulator value
//   y      : signed OUT_WIDTH rounded and saturated value
module fir_round_sat #(
    parameter int ACC_WIDTH = 35,
    parameter int FRAC_BITS = 15,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    output logic signed [OUT_WIDTH-1:0] y
);

    // One guard bit so adding the half-LSB can never wrap.
    localparam logic signed [ACC_WIDTH:0] HALF =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH:0] biased;
    logic signed [ACC_WIDTH:0] shifted;

    always_comb begin
        biased  = {acc_in[ACC_WIDTH-1], acc_in} + HALF;
        // Arithmetic shift of (x + half) floors, giving round-half-up.
        shifted = biased >>> FRAC_BITS;
        if (shifted > OUT_MAX) begin
            y = OUT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < OUT_MIN) begin
            y = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            y = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR MAC engine: one tap per cycle over K cycles, then
// one rounding cycle, then holds the result until the consumer takes it.
//   clk, rst         : clock, synchronous active-high reset
//   start / ready    : begin a computation (accepted only while ready)
//   tap_index        : tap select to the external sample selector and ROM
//   sample_in/coef_in: x[n-tap_index] and h[tap_index], same cycle
//   y_out / y_valid  : registered result and valid, y_ready handshake
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int K          = 8,
    parameter int FRAC_BITS  = 15,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          ready,
    output logic [$clog2(K)-1:0]          tap_index,
    input  logic signed [DATA_WIDTH-1:0]  sample_in,
    input  logic signed [COEF_WIDTH-1:0]  coef_in,
    output logic signed [OUT_WIDTH-1:0]   y_out,
    output logic                          y_valid,
    input  logic                          y_ready
);

    localparam int ACC_WIDTH = fir_acc_width(DATA_WIDTH, COEF_WIDTH, K);
    localparam int PROD_W    = DATA_WIDTH + COEF_WIDTH;
    localparam int TAP_W     = $clog2(K);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(K - 1);

    fir_state_t                  state_reg, state_next;
    logic [TAP_W-1:0]            tap_reg, tap_next;
    logic signed [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic signed [OUT_WIDTH-1:0] y_out_reg, y_out_next;
    logic                        y_valid_reg, y_valid_next;

    logic signed [PROD_W-1:0]    product;
    logic signed [ACC_WIDTH-1:0] product_ext;
    logic signed [OUT_WIDTH-1:0] rounded;

    assign product     = sample_in * coef_in;
    assign product_ext = {{(ACC_WIDTH - PROD_W){product[PROD_W-1]}}, product};

    fir_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_sat (
        .acc_in (acc_reg),
        .y      (rounded)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            tap_reg     <= '0;
            acc_reg     <= '0;
            y_out_reg   <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tap_reg     <= tap_next;
            acc_reg     <= acc_next;
            y_out_reg   <= y_out_next;
            y_valid_reg <= y_valid_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tap_next     = tap_reg;
        acc_next     = acc_reg;
        y_out_next   = y_out_reg;
        y_valid_next = y_valid_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    acc_next   = '0;
                    tap_next   = '0;
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_next = acc_reg + product_ext;
                if (tap_reg == LAST_TAP) begin
                    tap_next   = '0;
                    state_next = ST_ROUND;
                end else begin
                    tap_next = tap_reg + TAP_W'(1);
                end
            end
            ST_ROUND: begin
                y_out_next   = rounded;
                y_valid_next = 1'b1;
                state_next   = ST_HOLD;
            end
            ST_HOLD: begin
                // start is deliberately not looked at here, even on the
                // transfer cycle; a new run needs ready high first.
                if (y_ready) begin
                    y_valid_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ready     = (state_reg == ST_IDLE);
    assign tap_index = tap_reg;
    assign y_out     = y_out_reg;
    assign y_valid   = y_valid_reg;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine (K=8, FRAC_BITS=15, 16-bit widths).
// Inputs change and outputs are sampled on the falling edge.
module tb_fir_mac_engine;

    localparam int K = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               ready;
    logic [2:0]         tap_index;
    logic signed [15:0] sample_in;
    logic signed [15:0] coef_in;
    logic signed [15:0] y_out;
    logic               y_valid;
    logic               y_ready = 1'b0;

    logic signed [15:0] smp [K];
    logic signed [15:0] cof [K];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    int prev_rise = 0;
    int rise_cnt = 0;
    logic yv_prev = 1'b0;

    always #5 clk = ~clk;

    // External sample selector and coefficient ROM model.
    assign sample_in = smp[tap_index];
    assign coef_in   = cof[tap_index];

    fir_mac_engine #(
        .DATA_WIDTH (16),
        .COEF_WIDTH (16),
        .K          (K),
        .FRAC_BITS  (15),
        .OUT_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .tap_index (tap_index),
        .sample_in (sample_in),
        .coef_in   (coef_in),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .y_ready   (y_ready)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (y_valid && !yv_prev) begin
            prev_rise <= last_rise;
            last_rise <= cyc;
            rise_cnt  <= rise_cnt + 1;
        end
        yv_prev <= y_valid;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int s0, input int sstep, input int s_rest,
                           input int c_all, input bool_ramp);
        for (int i = 0; i < K; i++) begin
            if (bool_ramp) smp[i] = 16'(s0 + i * sstep);
            else           smp[i] = (i == 0) ? 16'(s0) : 16'(s_rest);
            cof[i] = 16'(c_all);
        end
    endtask

    // Caller is at a falling edge with the DUT in IDLE.
    task automatic run_txn(input string tag, input int exp_y, input int stall);
        int t;
        chk({tag, "_ready_idle"}, ready, 1);
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < K; i++) begin
            chk({tag, "_tap"}, tap_index, i);
            chk({tag, "_mac_ready"}, ready, 0);
            @(negedge clk);
        end
        // ROUND cycle
        chk({tag, "_round_tap"}, tap_index, 0);
        chk({tag, "_round_valid"}, y_valid, 0);
        @(negedge clk);
        chk({tag, "_latency"}, cyc - t, K + 2);
        chk({tag, "_valid"}, y_valid, 1);
        chk({tag, "_y"}, y_out, exp_y);
        chk({tag, "_hold_tap"}, tap_index, 0);
        for (int s = 0; s < stall; s++) begin
            start = 1'b1;
            @(negedge clk);
            chk({tag, "_stall_valid"}, y_valid, 1);
            chk({tag, "_stall_y"}, y_out, exp_y);
            chk({tag, "_stall_ready"}, ready, 0);
        end
        // Transfer cycle; start held high here only when stalling.
        start   = (stall > 0);
        y_ready = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        y_ready = 1'b0;
        chk({tag, "_post_ready"}, ready, 1);
        chk({tag, "_post_valid"}, y_valid, 0);
        chk({tag, "_post_y"}, y_out, exp_y);
        $display("txn %s: y_out=%0d expected=%0d stall=%0d", tag, y_out, exp_y, stall);
    endtask

    initial begin
        int rises_before;
        set_vec(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_valid", y_valid, 0);
        chk("rst_y", y_out, 0);
        chk("rst_tap", tap_index, 0);

        set_vec(10, 10, 0, 16384, 1);
        run_txn("nominal", 180, 0);
        set_vec(32767, 0, 0, 32767, 1);
        run_txn("pos_sat", 32767, 0);
        set_vec(-32768, 0, 0, 32767, 1);
        run_txn("neg_sat", -32768, 0);
        set_vec(1, 0, 0, 16384, 0);
        run_txn("round_p1", 1, 0);
        set_vec(-1, 0, 0, 16384, 0);
        run_txn("round_m1", 0, 0);
        set_vec(10, 10, 0, 16384, 1);
        run_txn("backpressure", 180, 5);

        // Reset while tap_index=3
        @(negedge clk);
        rises_before = rise_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_tap3", tap_index, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tap", tap_index, 0);
        chk("midrst_valid", y_valid, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_y", y_out, 0);
        repeat (K + 4) @(negedge clk);
        chk("midrst_no_output", rise_cnt, rises_before);
        $display("txn midrst: y_out=%0d expected=0", y_out);

        // Back-to-back
        set_vec(1, 0, 0, 16384, 0);
        run_txn("b2b_first", 1, 0);
        set_vec(10, 10, 0, 16384, 1);
        run_txn("b2b_second", 180, 0);
        chk("b2b_spacing", last_rise - prev_rise, K + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_mac_engine.md
FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the signed sample width.
REQ-002 The block SHALL have parameter COEF_WIDTH, default 16, meaning the signed coefficient width.
REQ-003 The block SHALL have parameter K, default 8, meaning the number of taps (K >= 2).
REQ-004 The block SHALL have parameter FRAC_BITS, default 15, meaning the coefficient fractional bits removed at output.
REQ-005 The block SHALL have parameter OUT_WIDTH, default 16, meaning the signed output width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port start, input, 1 bit: the delay line holds a new sample; begin one output computation.
REQ-009 The block SHALL have port ready, output, 1 bit: high only in IDLE; start is accepted only when ready=1.
REQ-010 The block SHALL have port tap_index, output, $clog2(K) bits: tap select driven to the sample selector and coefficient ROM.
REQ-011 The block SHALL have port sample_in, input, signed DATA_WIDTH bits: x[n-tap_index], combinational from the selector, same cycle.
REQ-012 The block SHALL have port coef_in, input, signed COEF_WIDTH bits: h[tap_index], same cycle.
REQ-013 The block SHALL have port y_out, output, signed OUT_WIDTH bits: the filtered output, registered.
REQ-014 The block SHALL have port y_valid, output, 1 bit: y_out is valid.
REQ-015 The block SHALL have port y_ready, input, 1 bit: the consumer accepts y_out; a transfer occurs when y_valid and y_ready are both high.

Function
REQ-016 The FSM SHALL have states IDLE, MAC, ROUND and HOLD.
REQ-017 In IDLE, start=1 SHALL clear the accumulator and move to MAC with tap_index=0; start=0 SHALL stay in IDLE.
REQ-018 Each MAC cycle SHALL perform acc <= acc + sample_in*coef_in (full-precision signed product) and increment tap_index.
REQ-019 The MAC accumulator SHALL be ACC_WIDTH = DATA_WIDTH+COEF_WIDTH+$clog2(K) bits and SHALL never overflow.
REQ-020 After the MAC cycle with tap_index=K-1, the FSM SHALL go to ROUND, and tap_index SHALL wrap to 0.
REQ-021 ROUND SHALL take one cycle: add 2^(FRAC_BITS-1), arithmetic-shift right by FRAC_BITS, saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], register into y_out, set y_valid=1, and go to HOLD.
REQ-022 Rounding SHALL be round-half-up (toward +infinity at exact halves).
REQ-023 Latency: with start accepted in cycle t, MAC SHALL span cycles t+1..t+K and y_valid SHALL first be high in cycle t+K+2.
REQ-024 In HOLD, y_out and y_valid SHALL stay stable until y_ready=1; on that transfer, y_valid SHALL drop and the FSM SHALL return to IDLE on the next edge.
REQ-025 start SHALL be ignored while ready=0 (MAC, ROUND, HOLD), including the HOLD transfer cycle.
REQ-026 tap_index SHALL be 0 in IDLE, ROUND and HOLD.
REQ-027 y_out SHALL retain its last value after the transfer until the next ROUND.

Reset
REQ-028 With rst=1 at a clock edge, the FSM SHALL go to IDLE, and acc, tap_index, y_out and y_valid SHALL become 0; ready SHALL be 1 the following cycle.
REQ-029 Reset mid-operation (any state) SHALL abort the computation with no y_valid pulse; rst SHALL take priority over start.

Structure
REQ-030 Shared package fir_pkg SHALL hold the FSM state encoding and the ACC_WIDTH derivation function, reused by the other FIR blocks.
REQ-031 Rounding and saturation SHALL live in the combinational sub-module fir_round_sat (ACC_WIDTH in, OUT_WIDTH out, FRAC_BITS parameter).

Verification (K=8, FRAC_BITS=15, all widths 16)
REQ-032 Bench SHALL cover nominal: samples 10,20,...,80 by tap, coef all 16384, start at t -> y_out=180 with y_valid first high at t+10, tap_index sequence 0..7.
REQ-033 Bench SHALL cover positive saturation: all samples 32767, coef 32767 -> y_out=32767; and negative saturation: samples -32768, coef 32767 -> y_out=-32768.
REQ-034 Bench SHALL cover rounding: sample 1 on tap 0, others 0, coef 16384 -> y_out=1; sample -1 -> y_out=0.
REQ-035 Bench SHALL cover backpressure: y_ready low 5 cycles after y_valid -> y_out stable, ready=0, start pulses ignored; y_ready=1 -> IDLE next cycle, ready=1.
REQ-036 Bench SHALL cover reset mid-MAC: rst in the cycle with tap_index=3 -> next cycle tap_index=0, y_valid=0, ready=1, y_out=0, no output produced.
REQ-037 Bench SHALL cover back-to-back: start reasserted the cycle ready returns -> second result correct, and consecutive y_valid rising edges are K+3 cycles apart.
